// File: rtl/gsensemu_gen.sv
// gsensemu_gen - emulated G-sensor (accelerometer) sample generator.
//
// Produces a 10-bit two's complement sample on oDIG once every SAMPLE_DIV
// clocks while enabled. Each sample slews the current value toward a target
// by at most SLEW_STEP LSB, without overshooting. The target comes from
// tilt requests: {0, AMOUNT, 00000}, bit-inverted for the negative direction.
//
// Optional feature macro: GSENSEMU_NOISE_EN adds +/-1 LSB LFSR dither to
// oDIG only. The default build has no dither.
//
// Ports:
//   iCLK         clock, rising edge
//   iRST         synchronous active-high reset
//   iENABLE      sample generation enable
//   iTILT_VALID  one-cycle strobe qualifying iTILT_AMOUNT / iTILT_DIR
//   iTILT_AMOUNT requested tilt magnitude (4 bits)
//   iTILT_DIR    requested direction, 1 = negative
//   oDIG         emulated sample, two's complement (10 bits)
//   oG_INT2      data-ready pulse, one cycle per new sample
//   oSETTLED     high while the current value equals the target
module gsensemu_gen #(
   parameter int SAMPLE_DIV = 50000,
   parameter int SLEW_STEP  = 8
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iENABLE,
   input  logic       iTILT_VALID,
   input  logic [3:0] iTILT_AMOUNT,
   input  logic       iTILT_DIR,
   output logic [9:0] oDIG,
   output logic       oG_INT2,
   output logic       oSETTLED
);

   localparam int DATA_W = 10;
   localparam int EXT_W  = DATA_W + 2;
   localparam int CNT_W  = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
   localparam logic signed [EXT_W-1:0] VMAX  = 12'sd511;
   localparam logic signed [EXT_W-1:0] VMIN  = -12'sd512;
   localparam logic signed [EXT_W-1:0] STEP  = EXT_W'(SLEW_STEP);
   localparam logic signed [EXT_W-1:0] NSTEP = -STEP;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_TRACK   = 2'd1,
      ST_SETTLED = 2'd2
   } state_t;

   // Clamp a widened intermediate back to the 10-bit signed range.
   function automatic logic signed [DATA_W-1:0] sat10(input logic signed [EXT_W-1:0] x);
      if (x > VMAX)
         return VMAX[DATA_W-1:0];
      else if (x < VMIN)
         return VMIN[DATA_W-1:0];
      else
         return x[DATA_W-1:0];
   endfunction

   // One slew step of c toward t; lands exactly on t when within reach.
   function automatic logic signed [DATA_W-1:0] slew(input logic signed [DATA_W-1:0] c,
                                                      input logic signed [DATA_W-1:0] t);
      logic signed [EXT_W-1:0] cx;
      logic signed [EXT_W-1:0] d;
      cx = {{2{c[DATA_W-1]}}, c};
      d  = {{2{t[DATA_W-1]}}, t} - cx;
      if (d > STEP)
         return sat10(cx + STEP);
      else if (d < NSTEP)
         return sat10(cx - STEP);
      else
         return t;
   endfunction

   state_t                   state;
   logic [CNT_W-1:0]         cnt;
   logic signed [DATA_W-1:0] cur;
   logic signed [DATA_W-1:0] tgt;
   logic signed [DATA_W-1:0] dig;
   logic                     int2;
   logic                     settled;

   logic                     tick;
   logic signed [DATA_W-1:0] tgt_new;
   logic                     tgt_chg;
   logic signed [DATA_W-1:0] cur_nxt;

`ifdef GSENSEMU_NOISE_EN
   localparam logic signed [EXT_W-1:0] PONE = 12'sd1;
   localparam logic signed [EXT_W-1:0] MONE = -12'sd1;
   logic [15:0] lfsr;
   logic        lfsr_fb;
   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
`endif

   assign tick    = iENABLE && (cnt == CNT_LAST);
   // Negative direction is the bitwise inverse so a parser can undo it exactly.
   assign tgt_new = iTILT_DIR ? ~{1'b0, iTILT_AMOUNT, 5'b00000} : {1'b0, iTILT_AMOUNT, 5'b00000};
   assign tgt_chg = iTILT_VALID && (tgt_new != tgt);
   assign cur_nxt = slew(cur, tgt);

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         cur     <= '0;
         tgt     <= '0;
         dig     <= '0;
         int2    <= 1'b0;
         settled <= 1'b0;
`ifdef GSENSEMU_NOISE_EN
         lfsr    <= 16'hACE1;
`endif
      end else begin
         int2 <= 1'b0;
         // The tick uses the registered target, so a strobe in the tick
         // cycle only takes effect from the following tick.
         if (iTILT_VALID)
            tgt <= tgt_new;

         if (!iENABLE) begin
            cnt     <= '0;
            state   <= ST_IDLE;
            settled <= 1'b0;
         end else begin
            if (tick) begin
               cnt  <= '0;
               cur  <= cur_nxt;
               int2 <= 1'b1;
`ifdef GSENSEMU_NOISE_EN
               dig  <= sat10({{2{cur_nxt[DATA_W-1]}}, cur_nxt} + (lfsr[0] ? PONE : MONE));
               lfsr <= {lfsr[14:0], lfsr_fb};
`else
               dig  <= cur_nxt;
`endif
            end else begin
               cnt <= cnt + 1'b1;
            end

            case (state)
               ST_IDLE: begin
                  state   <= ST_TRACK;
                  settled <= 1'b0;
               end
               ST_TRACK: begin
                  // A different target arriving in the tick cycle keeps us tracking.
                  if (tick && (cur_nxt == tgt) && !tgt_chg) begin
                     state   <= ST_SETTLED;
                     settled <= 1'b1;
                  end
               end
               ST_SETTLED: begin
                  if (tgt_chg) begin
                     state   <= ST_TRACK;
                     settled <= 1'b0;
                  end
               end
               default: begin
                  state   <= ST_IDLE;
                  settled <= 1'b0;
               end
            endcase
         end
      end
   end

   assign oDIG     = dig;
   assign oG_INT2  = int2;
   assign oSETTLED = settled;

endmodule

// File: tb/tb_gsensemu_gen.sv
// tb_gsensemu_gen - self-checking bench for gsensemu_gen (SAMPLE_DIV=4,
// SLEW_STEP=8, default build without dither). An integer reference model
// pushes each expected sample into a scoreboard queue; a negedge monitor pops
// it when oG_INT2 is due and compares.
module tb_gsensemu_gen;

   localparam int SD = 4;
   localparam int SS = 8;

   logic       iCLK = 1'b0;
   logic       iRST;
   logic       iENABLE;
   logic       iTILT_VALID;
   logic [3:0] iTILT_AMOUNT;
   logic       iTILT_DIR;
   logic [9:0] oDIG;
   logic       oG_INT2;
   logic       oSETTLED;

   gsensemu_gen #(.SAMPLE_DIV(SD), .SLEW_STEP(SS)) dut (
      .iCLK         (iCLK),
      .iRST         (iRST),
      .iENABLE      (iENABLE),
      .iTILT_VALID  (iTILT_VALID),
      .iTILT_AMOUNT (iTILT_AMOUNT),
      .iTILT_DIR    (iTILT_DIR),
      .oDIG         (oDIG),
      .oG_INT2      (oG_INT2),
      .oSETTLED     (oSETTLED)
   );

   always #5 iCLK = ~iCLK;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int cyc;
      int dig;
      bit set;
   } exp_t;

   exp_t q[$];
   int   cyc   = 0;
   int   m_cnt = 0;
   int   m_cur = 0;
   int   m_tgt = 0;
   int   m_dig = 0;
   int   m_st  = 0;   // 0 idle, 1 track, 2 settled
   bit   mon_on = 1'b0;

   always @(posedge iCLK) begin
      int a, nt, nc;
      bit tk, chg;
      cyc++;
      if (iRST) begin
         m_cnt = 0; m_cur = 0; m_tgt = 0; m_dig = 0; m_st = 0;
      end else begin
         a   = int'(iTILT_AMOUNT);
         nt  = iTILT_DIR ? -(a * 32) - 1 : a * 32;
         chg = iTILT_VALID && (nt != m_tgt);
         tk  = iENABLE && (m_cnt == SD - 1);
         nc  = m_cur;
         if (tk) begin
            if (m_tgt > m_cur)
               nc = (m_tgt - m_cur > SS) ? m_cur + SS : m_tgt;
            else if (m_tgt < m_cur)
               nc = (m_cur - m_tgt > SS) ? m_cur - SS : m_tgt;
         end
         if (!iENABLE) begin
            m_cnt = 0;
            m_st  = 0;
         end else begin
            case (m_st)
               0: m_st = 1;
               1: if (tk && nc == m_tgt && !chg) m_st = 2;
               2: if (chg) m_st = 1;
               default: m_st = 0;
            endcase
            m_cnt = tk ? 0 : m_cnt + 1;
         end
         if (tk) begin
            m_cur = nc;
            m_dig = nc;
            q.push_back('{cyc, nc, (m_st == 2)});
         end
         if (iTILT_VALID)
            m_tgt = nt;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge iCLK) begin
      bit   due;
      exp_t e;
      logic [9:0] md;
      if (mon_on) begin
         due = (q.size() > 0) && (q[0].cyc == cyc);
         check("int2", oG_INT2, due);
         if (due) begin
            e  = q.pop_front();
            md = e.dig[9:0];
            check("sample", oDIG, md);
            check("settled_at_sample", oSETTLED, e.set);
         end else begin
            md = m_dig[9:0];
            check("dig_hold", oDIG, md);
         end
         while (q.size() > 0 && q[0].cyc <= cyc)
            void'(q.pop_front());
         check("settled", oSETTLED, (m_st == 2));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tilt(input logic [3:0] amt, input logic dir);
      @(negedge iCLK);
      iTILT_VALID  = 1'b1;
      iTILT_AMOUNT = amt;
      iTILT_DIR    = dir;
      @(negedge iCLK);
      iTILT_VALID  = 1'b0;
   endtask

   task automatic wait_ticks(input int n);
      repeat (n * SD) @(negedge iCLK);
   endtask

   initial begin
      logic [9:0] inv;
      logic [9:0] d0;
      int         n;
      int         pulses;

      iRST = 1'b1; iENABLE = 1'b0; iTILT_VALID = 1'b0; iTILT_AMOUNT = '0; iTILT_DIR = 1'b0;
      @(negedge iCLK);
      mon_on = 1'b1;
      @(negedge iCLK);
      check("rst_dig", oDIG, 10'd0);
      check("rst_int2", oG_INT2, 1'b0);
      check("rst_settled", oSETTLED, 1'b0);
      iRST = 1'b0;
      repeat (3) @(negedge iCLK);

      // Enable with no target: pulses every SD cycles, value stays 0, settles.
      iENABLE = 1'b1;
      wait_ticks(3);
      check("idle_dig_zero", oDIG, 10'd0);
      check("idle_settled", oSETTLED, 1'b1);

      // Positive tilt of 3 -> 96.
      tilt(4'd3, 1'b0);
      wait_ticks(14);
      check("pos_final", oDIG, 10'd96);
      check("pos_settled", oSETTLED, 1'b1);
      check("pos_parse_amt", oDIG[8:5], 4'd3);
      check("pos_parse_dir", oDIG[9], 1'b0);

      // Reset, then negative tilt of 1 from 0 -> -33 with a final 1 LSB step.
      @(negedge iCLK);
      iRST = 1'b1;
      @(negedge iCLK);
      check("rst2_dig", oDIG, 10'd0);
      iRST = 1'b0;
      tilt(4'd1, 1'b1);
      wait_ticks(8);
      check("neg_final", oDIG, 10'h3DF);
      inv = ~oDIG;
      check("neg_parse_amt", inv[8:5], 4'd1);
      check("neg_parse_dir", oDIG[9], 1'b1);

      // Strobe in the tick cycle: that tick keeps the old target.
      n = 0;
      while (m_cnt != SD - 1 && n < 2 * SD) begin
         @(negedge iCLK);
         n++;
      end
      check("tick_align", m_cnt, SD - 1);
      iTILT_VALID = 1'b1; iTILT_AMOUNT = 4'd2; iTILT_DIR = 1'b0;
      @(negedge iCLK);
      iTILT_VALID = 1'b0;
      check("tick_old_tgt_pulse", oG_INT2, 1'b1);
      check("tick_old_tgt_dig", oDIG, 10'h3DF);
      repeat (SD) @(negedge iCLK);
      check("next_tick_moves", oDIG, 10'h3E7);

      // Disable mid-slew for 10 cycles, loading a new target meanwhile.
      wait_ticks(2);
      @(negedge iCLK);
      iENABLE = 1'b0;
      d0 = oDIG;
      pulses = 0;
      fork
         tilt(4'd5, 1'b1);
      join_none
      repeat (10) begin
         @(negedge iCLK);
         if (oG_INT2) pulses++;
      end
      check("dis_no_pulse", pulses, 0);
      check("dis_frozen", oDIG, d0);
      iENABLE = 1'b1;
      n = 0;
      do begin
         @(negedge iCLK);
         n++;
      end while (!oG_INT2 && n < 5 * SD);
      check("reenable_latency", n, SD);

      // Reset mid-slew abandons the slew.
      wait_ticks(2);
      iRST = 1'b1;
      @(negedge iCLK);
      check("midslew_rst_dig", oDIG, 10'd0);
      check("midslew_rst_int2", oG_INT2, 1'b0);
      iRST = 1'b0;

      // Back-to-back strobes: last wins (-65).
      tilt(4'd7, 1'b0);
      tilt(4'd2, 1'b1);
      wait_ticks(12);
      check("last_wins", oDIG, 10'h3BF);

      // Range extremes.
      tilt(4'd15, 1'b0);
      wait_ticks(72);
      check("max_pos", oDIG, 10'd480);
      tilt(4'd15, 1'b1);
      wait_ticks(124);
      check("max_neg", oDIG, 10'h21F);

      // Random enable / tilt traffic.
      repeat (400) begin
         @(negedge iCLK);
         iENABLE      = ($urandom_range(0, 9) != 0);
         iTILT_VALID  = ($urandom_range(0, 7) == 0);
         iTILT_AMOUNT = 4'($urandom_range(0, 15));
         iTILT_DIR    = 1'($urandom_range(0, 1));
      end
      @(negedge iCLK);
      iTILT_VALID = 1'b0;
      iENABLE     = 1'b1;
      wait_ticks(3);
      check("sb_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
